ingress_fabric_arbiter: RTL and testbench



---
 rtl/ingress_fabric_arbiter_pkg.sv | 30 +++
 rtl/ingress_fabric_arbiter_if.sv | 62 ++++++
 rtl/ingress_fabric_arbiter_rr_priority_select.sv | 30 +++
 rtl/ingress_fabric_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ingress_fabric_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ingress_fabric_arbiter_pkg.sv
// rtl/ingress_fabric_arbiter_pkg.sv - shared fabric types for the ingress arbiter
// Arbiter state, abort reasons, ingress port state and width helpers.
package ingress_fabric_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_STREAM = 2'd1,
    ARB_DRAIN  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    ABORT_NONE      = 2'd0,
    ABORT_MAX_WORDS = 2'd1,
    ABORT_TIMEOUT   = 2'd2
  } abort_reason_t;

  typedef enum logic [1:0] {
    PORT_EMPTY   = 2'd0,
    PORT_PENDING = 2'd1,
    PORT_GRANTED = 2'd2
  } inportstate_t;

  localparam int WORD_CNT_W       = 8;
  localparam int DRAIN_IDLE_LIMIT = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ingress_fabric_arbiter_if.sv
// rtl/ingress_fabric_arbiter_if.sv - grant, frame stream and egress signals of the arbiter
// Stats signals exist only with INGRESS_ARBITER_STATS_EN.
interface ingress_fabric_arbiter_if #(
  parameter int NUM_PORTS = 15
);
  import ingress_fabric_arbiter_pkg::*;

  localparam int IDX_W = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] frame_pending;
  logic                 egress_ready;
  logic [NUM_PORTS-1:0] forward_en;
  logic                 frame_valid;
  logic                 frame_last;
  logic [127:0]         frame_data;
  logic                 out_valid;
  logic                 out_last;
  logic [127:0]         out_data;
  logic [IDX_W-1:0]     out_src_port;
  logic                 out_abort;
`ifdef INGRESS_ARBITER_STATS_EN
  logic [31:0]          stat_frames;
  logic [31:0]          stat_aborts;
`endif

  modport slave (
`ifdef INGRESS_ARBITER_STATS_EN
    output stat_frames,
    output stat_aborts,
`endif
    input  frame_pending,
    input  egress_ready,
    input  frame_valid,
    input  frame_last,
    input  frame_data,
    output forward_en,
    output out_valid,
    output out_last,
    output out_data,
    output out_src_port,
    output out_abort
  );

  modport master (
`ifdef INGRESS_ARBITER_STATS_EN
    input  stat_frames,
    input  stat_aborts,
`endif
    output frame_pending,
    output egress_ready,
    output frame_valid,
    output frame_last,
    output frame_data,
    input  forward_en,
    input  out_valid,
    input  out_last,
    input  out_data,
    input  out_src_port,
    input  out_abort
  );

endinterface

// File: rtl/ingress_fabric_arbiter_rr_priority_select.sv
// rtl/ingress_fabric_arbiter_rr_priority_select.sv - combinational round-robin pick
// First set request strictly after last_grant, wrapping; last_grant itself is checked last.
module rr_priority_select
  import ingress_fabric_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 15,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx_o = '0;
    valid_o     = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_PORTS);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        grant_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/ingress_fabric_arbiter.sv
// rtl/ingress_fabric_arbiter.sv - round-robin ingress frame arbiter with abort/drain
// Optional saturating frame/abort counters under INGRESS_ARBITER_STATS_EN.
module ingress_fabric_arbiter
  import ingress_fabric_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 15,
  parameter int MAX_WORDS    = 128,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  ingress_fabric_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_PORTS);
  localparam int IC_W  = idx_w((IDLE_TIMEOUT > DRAIN_IDLE_LIMIT) ? IDLE_TIMEOUT : DRAIN_IDLE_LIMIT);

  localparam logic [WORD_CNT_W-1:0] WORD_LAST    = WORD_CNT_W'(MAX_WORDS - 1);
  localparam logic [IC_W-1:0]       TIMEOUT_LAST = IC_W'(IDLE_TIMEOUT - 1);
  localparam logic [IC_W-1:0]       DRAIN_LAST   = IC_W'(DRAIN_IDLE_LIMIT - 1);
  localparam logic [IDX_W-1:0]      GRANT_INIT   = IDX_W'(NUM_PORTS - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_PORTS-1:0]   fe_q, fe_d;
  logic [IDX_W-1:0]       src_q, src_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [IC_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [127:0]           out_data_q, out_data_d;
  logic                   out_abort_q, out_abort_d;
  abort_reason_t          reason_d;

  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req_i        (bus.frame_pending),
    .last_grant_i (last_grant_q),
    .grant_idx_o  (sel_idx),
    .valid_o      (sel_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      fe_q         <= '0;
      src_q        <= '0;
      last_grant_q <= GRANT_INIT;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fe_q         <= fe_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      out_abort_q  <= out_abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fe_d         = fe_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_data_d   = out_data_q;
    reason_d     = ABORT_NONE;

    case (state_q)
      ARB_IDLE: begin
        // egress_ready only matters at the moment of selection
        if (bus.egress_ready && sel_valid) begin
          fe_d         = NUM_PORTS'(1) << sel_idx;
          src_d        = sel_idx;
          last_grant_d = sel_idx;
          word_cnt_d   = '0;
          idle_cnt_d   = '0;
          state_d      = ARB_STREAM;
        end
      end

      ARB_STREAM: begin
        if (bus.frame_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.frame_data;
          out_last_d  = bus.frame_last;
          idle_cnt_d  = '0;
          word_cnt_d  = word_cnt_q + 1'b1;
          if (bus.frame_last) begin
            fe_d    = '0;
            state_d = ARB_IDLE;
          end else if (word_cnt_q == WORD_LAST) begin
            out_last_d = 1'b1;
            reason_d   = ABORT_MAX_WORDS;
            fe_d       = '0;
            state_d    = ARB_DRAIN;
          end
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
          reason_d   = ABORT_TIMEOUT;
          fe_d       = '0;
          idle_cnt_d = '0;
          state_d    = ARB_DRAIN;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      ARB_DRAIN: begin
        // swallow the tail of a truncated frame until its last word or a quiet gap
        if (bus.frame_valid) begin
          idle_cnt_d = '0;
          if (bus.frame_last) begin
            state_d = ARB_IDLE;
          end
        end else if (idle_cnt_q == DRAIN_LAST) begin
          idle_cnt_d = '0;
          state_d    = ARB_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: begin
        fe_d    = '0;
        state_d = ARB_IDLE;
      end
    endcase

    out_abort_d = (reason_d != ABORT_NONE);
  end

  assign bus.forward_en   = fe_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_src_port = src_q;
  assign bus.out_abort    = out_abort_q;

`ifdef INGRESS_ARBITER_STATS_EN
  logic [31:0] stat_frames_q;
  logic [31:0] stat_aborts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_aborts_q <= '0;
    end else begin
      if (out_last_d && !out_abort_d && (stat_frames_q != '1)) begin
        stat_frames_q <= stat_frames_q + 32'd1;
      end
      if (out_abort_d && (stat_aborts_q != '1)) begin
        stat_aborts_q <= stat_aborts_q + 32'd1;
      end
    end
  end

  assign bus.stat_frames = stat_frames_q;
  assign bus.stat_aborts = stat_aborts_q;
`endif

endmodule

// File: tb/tb_ingress_fabric_arbiter.sv
// tb/tb_ingress_fabric_arbiter.sv - self-checking bench for ingress_fabric_arbiter
// Directed scenarios plus randomized traffic against a round-robin reference model.
module tb_ingress_fabric_arbiter;
  import ingress_fabric_arbiter_pkg::*;

  localparam int N  = 15;
  localparam int MW = 8;
  localparam int IT = 64;
  localparam int IW = idx_w(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ingress_fabric_arbiter_if #(.NUM_PORTS(N)) bus();

  ingress_fabric_arbiter #(
    .NUM_PORTS    (N),
    .MAX_WORDS    (MW),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int last_grant_m;
  int frames_m;
  int aborts_m;

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
    bus.frame_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.frame_pending = '0;
    bus.egress_ready  = 1'b0;
    idle_inputs();
    repeat (3) tick();
    n_checks++; if (bus.forward_en !== '0) $display("FAIL reset_fe: got %h expected 0", bus.forward_en); else n_pass++;
    n_checks++; if ({bus.out_valid, bus.out_last, bus.out_abort} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.out_valid, bus.out_last, bus.out_abort}); else n_pass++;
    n_checks++; if (bus.out_data !== '0) $display("FAIL reset_data: got %h expected 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_src_port !== '0) $display("FAIL reset_src: got %0d expected 0", bus.out_src_port); else n_pass++;
`ifdef INGRESS_ARBITER_STATS_EN
    n_checks++; if ({bus.stat_frames, bus.stat_aborts} !== 64'd0) $display("FAIL reset_stats: got %h expected 0", {bus.stat_frames, bus.stat_aborts}); else n_pass++;
`endif
    rst = 1'b0;
    last_grant_m = N - 1;
    frames_m = 0;
    aborts_m = 0;
    tick();
  endtask

  task automatic test_first_grant();
    logic [127:0] d [3];
    logic [127:0] tail;
    for (int i = 0; i < 3; i++) d[i] = rand128();
    bus.frame_pending = 15'h0005;
    bus.egress_ready  = 1'b1;
    tick();
    n_checks++; if (bus.forward_en !== 15'h0001) $display("FAIL first_grant_fe: got %h expected 0001", bus.forward_en); else n_pass++;
    n_checks++; if (bus.out_src_port !== IW'(0)) $display("FAIL first_grant_src: got %0d expected 0", bus.out_src_port); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.frame_valid = 1'b1;
      bus.frame_data  = d[i];
      bus.frame_last  = (i == 2);
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d[i] || bus.out_last !== (i == 2) || bus.out_abort !== 1'b0)
        $display("FAIL stream3_word%0d: got v%b l%b a%b %h expected v1 l%b a0 %h", i, bus.out_valid, bus.out_last, bus.out_abort, bus.out_data, (i == 2), d[i]);
      else n_pass++;
      n_checks++; if (bus.out_src_port !== IW'(0)) $display("FAIL stream3_src%0d: got %0d expected 0", i, bus.out_src_port); else n_pass++;
      n_checks++;
      if (bus.forward_en !== ((i == 2) ? 15'h0000 : 15'h0001)) $display("FAIL stream3_fe%0d: got %h expected %h", i, bus.forward_en, (i == 2) ? 15'h0000 : 15'h0001);
      else n_pass++;
    end
    bus.frame_valid = 1'b1;
    bus.frame_last  = 1'b0;
    bus.frame_data  = rand128();
    tick();
    n_checks++; if (bus.forward_en !== 15'h0004) $display("FAIL second_grant_fe: got %h expected 0004", bus.forward_en); else n_pass++;
    n_checks++; if (bus.out_src_port !== IW'(2)) $display("FAIL second_grant_src: got %0d expected 2", bus.out_src_port); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL idle_word_ignored: got %b expected 0", bus.out_valid); else n_pass++;
    tail = rand128();
    bus.frame_data    = tail;
    bus.frame_last    = 1'b1;
    bus.frame_pending = '0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== tail) $display("FAIL second_frame_last: got v%b l%b %h expected v1 l1 %h", bus.out_valid, bus.out_last, bus.out_data, tail); else n_pass++;
    idle_inputs();
    frames_m += 2;
    last_grant_m = 2;
    repeat (3) tick();
  endtask

  task automatic test_single_requester();
    int waited;
    bus.frame_pending = 15'h0080;
    bus.egress_ready  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      waited = 0;
      while (bus.forward_en === '0 && waited < 6) begin
        tick();
        waited++;
      end
      n_checks++; if (waited !== 1) $display("FAIL single_gap%0d: got %0d cycles expected 1", f, waited); else n_pass++;
      n_checks++; if (bus.forward_en !== 15'h0080 || bus.out_src_port !== IW'(7)) $display("FAIL single_grant%0d: got %h/%0d expected 0080/7", f, bus.forward_en, bus.out_src_port); else n_pass++;
      bus.frame_valid = 1'b1;
      bus.frame_data  = rand128();
      tick();
      bus.frame_last = 1'b1;
      if (f == 2) bus.frame_pending = '0;
      tick();
      idle_inputs();
      n_checks++; if (bus.out_last !== 1'b1 || bus.forward_en !== '0) $display("FAIL single_end%0d: got l%b fe %h expected l1 fe 0", f, bus.out_last, bus.forward_en); else n_pass++;
    end
    frames_m += 3;
    last_grant_m = 7;
    repeat (2) tick();
  endtask

  task automatic test_max_words();
    logic [127:0] d;
    bus.frame_pending = 15'h0008;
    tick();
    n_checks++; if (bus.forward_en !== 15'h0008) $display("FAIL maxw_grant: got %h expected 0008", bus.forward_en); else n_pass++;
    for (int w = 1; w <= 10; w++) begin
      d = rand128();
      bus.frame_valid = 1'b1;
      bus.frame_data  = d;
      bus.frame_last  = (w == 10);
      if (w == 10) bus.frame_pending = '0;
      tick();
      if (w < MW) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== 1'b0 || bus.out_abort !== 1'b0) $display("FAIL maxw_word%0d: got v%b l%b a%b expected v1 l0 a0", w, bus.out_valid, bus.out_last, bus.out_abort); else n_pass++;
      end else if (w == MW) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== 1'b1 || bus.out_abort !== 1'b1) $display("FAIL maxw_abort_word: got v%b l%b a%b expected v1 l1 a1", bus.out_valid, bus.out_last, bus.out_abort); else n_pass++;
        n_checks++; if (bus.forward_en !== '0) $display("FAIL maxw_fe_drop: got %h expected 0", bus.forward_en); else n_pass++;
      end else begin
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_abort !== 1'b0) $display("FAIL maxw_drain_word%0d: got v%b a%b expected v0 a0", w, bus.out_valid, bus.out_abort); else n_pass++;
      end
    end
    idle_inputs();
    aborts_m++;
    repeat (2) tick();
`ifdef INGRESS_ARBITER_STATS_EN
    n_checks++; if (bus.stat_aborts !== 32'(aborts_m)) $display("FAIL maxw_stat_aborts: got %0d expected %0d", bus.stat_aborts, aborts_m); else n_pass++;
    n_checks++; if (bus.stat_frames !== 32'(frames_m)) $display("FAIL maxw_stat_frames: got %0d expected %0d", bus.stat_frames, frames_m); else n_pass++;
`endif
    bus.frame_pending = 15'h0008;
    tick();
    n_checks++; if (bus.forward_en !== 15'h0008) $display("FAIL exact_grant: got %h expected 0008", bus.forward_en); else n_pass++;
    for (int w = 1; w <= MW; w++) begin
      bus.frame_valid = 1'b1;
      bus.frame_data  = rand128();
      bus.frame_last  = (w == MW);
      if (w == MW) bus.frame_pending = '0;
      tick();
    end
    idle_inputs();
    n_checks++; if (bus.out_last !== 1'b1 || bus.out_abort !== 1'b0 || bus.forward_en !== '0) $display("FAIL exact_last_wins: got l%b a%b fe %h expected l1 a0 fe 0", bus.out_last, bus.out_abort, bus.forward_en); else n_pass++;
    frames_m++;
    last_grant_m = 3;
    repeat (2) tick();
  endtask

  task automatic test_idle_timeout();
    int first_abort;
    int abort_cycles;
    bus.frame_pending = 15'h0200;
    tick();
    n_checks++; if (bus.forward_en !== 15'h0200) $display("FAIL tmo_grant: got %h expected 0200", bus.forward_en); else n_pass++;
    for (int w = 0; w < 2; w++) begin
      bus.frame_valid = 1'b1;
      bus.frame_data  = rand128();
      tick();
    end
    idle_inputs();
    bus.frame_pending = '0;
    first_abort  = -1;
    abort_cycles = 0;
    for (int t = 1; t <= IT + 2; t++) begin
      tick();
      if (bus.out_abort === 1'b1) begin
        abort_cycles++;
        if (first_abort < 0) first_abort = t;
      end
      if (t == IT - 1) begin
        n_checks++; if (bus.forward_en !== 15'h0200) $display("FAIL tmo_grant_held: got %h expected 0200", bus.forward_en); else n_pass++;
      end
      if (t == IT) begin
        n_checks++; if (bus.forward_en !== '0 || bus.out_valid !== 1'b0) $display("FAIL tmo_fe_drop: got fe %h v%b expected 0 v0", bus.forward_en, bus.out_valid); else n_pass++;
      end
    end
    n_checks++; if (first_abort !== IT) $display("FAIL tmo_abort_cycle: got %0d expected %0d", first_abort, IT); else n_pass++;
    n_checks++; if (abort_cycles !== 1) $display("FAIL tmo_abort_pulse: got %0d cycles expected 1", abort_cycles); else n_pass++;
    bus.frame_valid = 1'b1;
    bus.frame_data  = rand128();
    tick();
    idle_inputs();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL tmo_drain_discard: got %b expected 0", bus.out_valid); else n_pass++;
    aborts_m++;
    last_grant_m = 9;
    repeat (6) tick();
    bus.frame_pending = 15'h0010;
    tick();
    n_checks++; if (bus.forward_en !== 15'h0010) $display("FAIL tmo_regrant: got %h expected 0010", bus.forward_en); else n_pass++;
    bus.frame_valid   = 1'b1;
    bus.frame_last    = 1'b1;
    bus.frame_pending = '0;
    tick();
    idle_inputs();
    frames_m++;
    last_grant_m = 4;
    repeat (2) tick();
  endtask

  task automatic test_egress_block();
    bit blocked_ok;
    int exp;
    bus.frame_pending = '1;
    bus.egress_ready  = 1'b0;
    blocked_ok = 1'b1;
    repeat (20) begin
      tick();
      if (bus.forward_en !== '0) blocked_ok = 1'b0;
    end
    n_checks++; if (blocked_ok !== 1'b1) $display("FAIL egress_block: got a grant expected none for 20 cycles"); else n_pass++;
    exp = rr_next('1, last_grant_m);
    bus.egress_ready = 1'b1;
    tick();
    n_checks++; if (bus.forward_en !== (15'(1) << exp) || bus.out_src_port !== IW'(exp)) $display("FAIL egress_release: got %h/%0d expected %h/%0d", bus.forward_en, bus.out_src_port, 15'(1) << exp, exp); else n_pass++;
    bus.frame_valid   = 1'b1;
    bus.frame_last    = 1'b1;
    bus.frame_pending = '0;
    tick();
    idle_inputs();
    frames_m++;
    last_grant_m = exp;
    repeat (2) tick();
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] pend;
    logic [127:0] d;
    logic [N-1:0] exp_fe;
    int exp, len, waited;
    pend = N'($urandom_range(1, (1 << N) - 1));
    bus.frame_pending = pend;
    bus.egress_ready  = 1'b1;
    for (int fr = 0; fr < 40; fr++) begin
      exp = rr_next(pend, last_grant_m);
      waited = 0;
      while (bus.forward_en === '0 && waited < 6) begin
        tick();
        waited++;
      end
      n_checks++; if (bus.forward_en !== (15'(1) << exp) || bus.out_src_port !== IW'(exp)) $display("FAIL rnd_grant%0d: got %h/%0d expected %h/%0d", fr, bus.forward_en, bus.out_src_port, 15'(1) << exp, exp); else n_pass++;
      last_grant_m = exp;
      len = $urandom_range(1, 10);
      for (int w = 1; w <= len; w++) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rnd_gap_valid%0d: got %b expected 0", fr, bus.out_valid); else n_pass++;
        end
        d = rand128();
        bus.frame_valid = 1'b1;
        bus.frame_data  = d;
        bus.frame_last  = (w == len);
        if (w == len) begin
          pend = (fr == 39) ? '0 : N'($urandom_range(1, (1 << N) - 1));
          bus.frame_pending = pend;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.frame_pending = N'($urandom());
        end
        tick();
        idle_inputs();
        exp_fe = (w < len && w < MW) ? (15'(1) << exp) : '0;
        if (w < MW || (w == MW && w == len)) begin
          n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== (w == len) || bus.out_abort !== 1'b0) $display("FAIL rnd_word%0d_%0d: got v%b l%b a%b expected v1 l%b a0", fr, w, bus.out_valid, bus.out_last, bus.out_abort, (w == len)); else n_pass++;
        end else if (w == MW) begin
          n_checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_abort !== 1'b1) $display("FAIL rnd_abort%0d: got v%b l%b a%b expected v1 l1 a1", fr, bus.out_valid, bus.out_last, bus.out_abort); else n_pass++;
        end else begin
          n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rnd_drain%0d_%0d: got %b expected 0", fr, w, bus.out_valid); else n_pass++;
        end
        n_checks++; if (bus.forward_en !== exp_fe) $display("FAIL rnd_fe%0d_%0d: got %h expected %h", fr, w, bus.forward_en, exp_fe); else n_pass++;
      end
      if (len > MW) aborts_m++;
      else frames_m++;
    end
    repeat (3) tick();
`ifdef INGRESS_ARBITER_STATS_EN
    n_checks++; if (bus.stat_frames !== 32'(frames_m) || bus.stat_aborts !== 32'(aborts_m)) $display("FAIL rnd_stats: got %0d/%0d expected %0d/%0d", bus.stat_frames, bus.stat_aborts, frames_m, aborts_m); else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    int exp;
    exp = rr_next(15'h0040, last_grant_m);
    bus.frame_pending = 15'h0040;
    bus.egress_ready  = 1'b1;
    tick();
    n_checks++; if (bus.forward_en !== (15'(1) << exp)) $display("FAIL arst_grant: got %h expected %h", bus.forward_en, 15'(1) << exp); else n_pass++;
    bus.frame_valid = 1'b1;
    bus.frame_data  = rand128();
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.forward_en !== '0) $display("FAIL arst_fe_immediate: got %h expected 0", bus.forward_en); else n_pass++;
    n_checks++; if (bus.out_abort !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL arst_outputs: got a%b v%b expected a0 v0", bus.out_abort, bus.out_valid); else n_pass++;
    repeat (2) tick();
    n_checks++; if (bus.out_abort !== 1'b0) $display("FAIL arst_no_abort: got %b expected 0", bus.out_abort); else n_pass++;
    bus.frame_pending = '1;
    rst = 1'b0;
    last_grant_m = N - 1;
    frames_m = 0;
    aborts_m = 0;
`ifdef INGRESS_ARBITER_STATS_EN
    n_checks++; if ({bus.stat_frames, bus.stat_aborts} !== 64'd0) $display("FAIL arst_stats: got %h expected 0", {bus.stat_frames, bus.stat_aborts}); else n_pass++;
`endif
    tick();
    n_checks++; if (bus.forward_en !== 15'h0001 || bus.out_src_port !== IW'(0)) $display("FAIL arst_port0: got %h/%0d expected 0001/0", bus.forward_en, bus.out_src_port); else n_pass++;
    bus.frame_valid   = 1'b1;
    bus.frame_last    = 1'b1;
    bus.frame_pending = '0;
    tick();
    idle_inputs();
    n_checks++; if (bus.out_last !== 1'b1 || bus.out_abort !== 1'b0) $display("FAIL arst_frame: got l%b a%b expected l1 a0", bus.out_last, bus.out_abort); else n_pass++;
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_grant();
    test_single_requester();
    test_max_words();
    test_idle_timeout();
    test_egress_block();
    test_random_traffic();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
